// File: rtl/riscv_core_rf_pkg.sv
// Shared types and constants for the RV64 multi-port integer register file.
package riscv_core_rf_pkg;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;

    localparam int unsigned RF_SP_IDX = 2;
    localparam int unsigned RF_GP_IDX = 3;

    localparam logic [63:0] RF_SP_INIT_DEF = 64'h0000_0000_7fff_fff0;
    localparam logic [63:0] RF_GP_INIT_DEF = 64'h0000_0000_1000_0000;

endpackage

// File: rtl/riscv_core_rf_wsel.sv
// Write-port priority selector: reports whether any enabled write port targets
// the query address and returns its data, with the highest port index winning.
module riscv_core_rf_wsel #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned AW   = 5,
    parameter int unsigned NW   = 1
) (
    input  logic [NW-1:0]      we,
    input  logic [NW*AW-1:0]   wa,
    input  logic [NW*XLEN-1:0] wd,
    input  logic [AW-1:0]      addr,
    output logic               hit,
    output logic [XLEN-1:0]    data
);

    // Ascending scan so a later (higher) port overrides an earlier match.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned k = 0; k < NW; k++) begin
            if (we[k] && (wa[k*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wd[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/riscv_core_rf_mp.sv
// RV64 multi-port integer register file with write-through bypass and an
// architectural-value init sequencer. Optional pending-write scoreboard: RF_SCOREBOARD_EN.
module riscv_core_rf_mp
    import riscv_core_rf_pkg::*;
#(
    parameter int unsigned     XLEN    = 64,
    parameter int unsigned     NREG    = 32,
    parameter int unsigned     NR      = 2,
    parameter int unsigned     NW      = 1,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(RF_SP_INIT_DEF),
    parameter logic [XLEN-1:0] GP_INIT = XLEN'(RF_GP_INIT_DEF)
) (
    input  logic                       i_rf_clk,
    input  logic                       i_rf_rst,
    input  logic [NW-1:0]              i_rf_we,
    input  logic [NW*$clog2(NREG)-1:0] i_rf_wa,
    input  logic [NW*XLEN-1:0]         i_rf_wd,
    input  logic [NR*$clog2(NREG)-1:0] i_rf_ra,
    output logic [NR*XLEN-1:0]         o_rf_rd,
`ifdef RF_SCOREBOARD_EN
    input  logic                       i_rf_sb_set,
    input  logic [$clog2(NREG)-1:0]    i_rf_sb_sa,
    output logic [NR-1:0]              o_rf_busy,
`endif
    output logic                       o_rf_ready
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = AW + 1;

    rf_state_e         state, next_state;
    logic [CW-1:0]     cnt, next_cnt;
    logic [XLEN-1:0]   init_val;
    logic [NW-1:0]     we_eff;
    logic [XLEN-1:0]   rf [NREG];
    logic [NREG-1:1]   wr_hit;
    logic [XLEN-1:0]   wr_data [1:NREG-1];
    logic [NR-1:0]     rd_hit;

    always_ff @(posedge i_rf_clk) begin
        if (i_rf_rst) begin
            state <= RF_INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            RF_INIT: begin
                next_cnt = cnt + 1'b1;
                if (cnt == CW'(NREG - 1)) next_state = RF_READY;
            end
            RF_READY: ;
            default: next_state = RF_INIT;
        endcase
    end

    always_comb begin
        init_val = '0;
        if (cnt == CW'(RF_SP_IDX)) init_val = SP_INIT;
        else if (cnt == CW'(RF_GP_IDX)) init_val = GP_INIT;
    end

    assign o_rf_ready = (state == RF_READY);
    assign we_eff     = i_rf_we & {NW{o_rf_ready}};

    // One selector per register resolves multi-port writes; x0 has none, so it is never written.
    for (genvar r = 1; r < NREG; r++) begin : g_wr
        riscv_core_rf_wsel #(.XLEN(XLEN), .AW(AW), .NW(NW)) u_wsel (
            .we   (we_eff),
            .wa   (i_rf_wa),
            .wd   (i_rf_wd),
            .addr (AW'(r)),
            .hit  (wr_hit[r]),
            .data (wr_data[r])
        );
    end

    always_ff @(posedge i_rf_clk) begin
        if (!i_rf_rst) begin
            if (state == RF_INIT) begin
                rf[cnt[AW-1:0]] <= init_val;
            end else begin
                for (int unsigned r = 1; r < NREG; r++) begin
                    if (wr_hit[r]) rf[r] <= wr_data[r];
                end
            end
        end
    end

    for (genvar j = 0; j < NR; j++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] byp;

        assign ra = i_rf_ra[j*AW +: AW];

        riscv_core_rf_wsel #(.XLEN(XLEN), .AW(AW), .NW(NW)) u_wsel (
            .we   (we_eff),
            .wa   (i_rf_wa),
            .wd   (i_rf_wd),
            .addr (ra),
            .hit  (rd_hit[j]),
            .data (byp)
        );

        assign o_rf_rd[j*XLEN +: XLEN] = ((ra == '0) || !o_rf_ready) ? '0 :
                                         rd_hit[j] ? byp : rf[ra];
    end

`ifdef RF_SCOREBOARD_EN
    logic [NREG-1:0] busy;

    // Set takes priority over a same-cycle clearing write; busy[0] stays clear.
    always_ff @(posedge i_rf_clk) begin
        if (i_rf_rst || (state == RF_INIT)) begin
            busy <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (i_rf_sb_set && (i_rf_sb_sa == AW'(r))) busy[r] <= 1'b1;
                else if (wr_hit[r]) busy[r] <= 1'b0;
            end
        end
    end

    for (genvar j = 0; j < NR; j++) begin : g_busy
        assign o_rf_busy[j] = busy[i_rf_ra[j*AW +: AW]] & ~rd_hit[j];
    end
`endif

endmodule

// File: tb/tb_riscv_core_rf_mp.sv
// Directed self-checking bench for riscv_core_rf_mp (NREG=32, NR=2, NW=2).
module tb_riscv_core_rf_mp;

    localparam logic [63:0] SP = 64'h0000_0000_7fff_fff0;
    localparam logic [63:0] GP = 64'h0000_0000_1000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][63:0] wd;
    logic [1:0][4:0]  ra;
    logic [1:0][63:0] rd;
    logic             ready;
`ifdef RF_SCOREBOARD_EN
    logic             sb_set;
    logic [4:0]       sb_sa;
    logic [1:0]       busy;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_core_rf_mp #(.XLEN(64), .NREG(32), .NR(2), .NW(2)) dut (
        .i_rf_clk   (clk),
        .i_rf_rst   (rst),
        .i_rf_we    (we),
        .i_rf_wa    (wa),
        .i_rf_wd    (wd),
        .i_rf_ra    (ra),
        .o_rf_rd    (rd),
`ifdef RF_SCOREBOARD_EN
        .i_rf_sb_set(sb_set),
        .i_rf_sb_sa (sb_sa),
        .o_rf_busy  (busy),
`endif
        .o_rf_ready (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int rise_at;
        rst = 1'b1;
        repeat (3) tick();
        ra = '{5'd2, 5'd3};
        #1;
        checks++;
        if (ready !== 1'b0 || rd !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rd=%h, required ready=0 rd=0", ready, rd);
        end
        rst = 1'b0;
        rise_at = 0;
        for (int i = 1; i <= 40 && rise_at == 0; i++) begin
            tick();
            if (ready === 1'b1) rise_at = i;
        end
        checks++;
        if (rise_at != 32) begin
            errors++;
            $display("FAIL init_ready_edges: rose after %0d edges, required 32", rise_at);
        end
        ra = '{5'd3, 5'd2};
        #1;
        checks++;
        if (rd[0] !== SP || rd[1] !== GP) begin
            errors++;
            $display("FAIL init_sp_gp: x2=%h x3=%h, required %h %h", rd[0], rd[1], SP, GP);
        end
        ra = '{5'd0, 5'd5};
        #1;
        checks++;
        if (rd[0] !== 64'd0) begin
            errors++;
            $display("FAIL init_x5: got %h, required 0", rd[0]);
        end
    endtask

    task automatic test_init_restart();
        int rise_at;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 2'b01;
        wa = '{5'd0, 5'd5};
        wd = '{64'd0, 64'hdead_beef};
        ra = '{5'd0, 5'd2};
        rise_at = 0;
        for (int i = 1; i <= 40 && rise_at == 0; i++) begin
            if (i == 20) begin
                checks++;
                if (rd[0] !== 64'd0) begin
                    errors++;
                    $display("FAIL init_read_zero: got %h, required 0", rd[0]);
                end
            end
            tick();
            if (ready === 1'b1) rise_at = i;
        end
        we = 2'b00;
        checks++;
        if (rise_at != 32) begin
            errors++;
            $display("FAIL restart_ready_edges: rose after %0d edges, required 32", rise_at);
        end
        ra = '{5'd2, 5'd5};
        #1;
        checks++;
        if (rd[0] !== 64'd0 || rd[1] !== SP) begin
            errors++;
            $display("FAIL init_we_ignored: x5=%h x2=%h, required 0 %h", rd[0], rd[1], SP);
        end
    endtask

    task automatic test_multi_write();
        we = 2'b11;
        wa = '{5'd7, 5'd7};
        wd = '{64'h5555, 64'hAAAA};
        ra = '{5'd7, 5'd7};
        #1;
        checks++;
        if (rd[0] !== 64'h5555 || rd[1] !== 64'h5555) begin
            errors++;
            $display("FAIL multi_write_bypass: rd0=%h rd1=%h, required 5555", rd[0], rd[1]);
        end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (rd[0] !== 64'h5555) begin
            errors++;
            $display("FAIL multi_write_stored: got %h, required 5555", rd[0]);
        end
    endtask

    task automatic test_x0();
        we = 2'b01;
        wa = '{5'd0, 5'd0};
        wd = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        ra = '{5'd7, 5'd0};
        #1;
        checks++;
        if (rd[0] !== 64'd0) begin
            errors++;
            $display("FAIL x0_same_cycle: got %h, required 0", rd[0]);
        end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (rd[0] !== 64'd0 || rd[1] !== 64'h5555) begin
            errors++;
            $display("FAIL x0_next_cycle: rd0=%h rd1=%h, required 0 5555", rd[0], rd[1]);
        end
    endtask

    task automatic test_back_to_back();
        we = 2'b10;
        wa = '{5'd10, 5'd0};
        wd = '{64'h1111, 64'd0};
        ra = '{5'd11, 5'd10};
        #1;
        checks++;
        if (rd[0] !== 64'h1111) begin
            errors++;
            $display("FAIL b2b_first: got %h, required 1111", rd[0]);
        end
        tick();
        we = 2'b11;
        wa = '{5'd11, 5'd10};
        wd = '{64'h3333, 64'h2222};
        #1;
        checks++;
        if (rd[0] !== 64'h2222 || rd[1] !== 64'h3333) begin
            errors++;
            $display("FAIL b2b_second: rd0=%h rd1=%h, required 2222 3333", rd[0], rd[1]);
        end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (rd[0] !== 64'h2222 || rd[1] !== 64'h3333) begin
            errors++;
            $display("FAIL b2b_stored: rd0=%h rd1=%h, required 2222 3333", rd[0], rd[1]);
        end
    endtask

`ifdef RF_SCOREBOARD_EN
    task automatic test_scoreboard();
        sb_set = 1'b1;
        sb_sa  = 5'd9;
        ra = '{5'd0, 5'd9};
        tick();
        sb_set = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b1 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL sb_set: busy=%b, required 01", busy);
        end
        we = 2'b01;
        wa = '{5'd0, 5'd9};
        wd = '{64'd0, 64'h99};
        #1;
        checks++;
        if (busy[0] !== 1'b0 || rd[0] !== 64'h99) begin
            errors++;
            $display("FAIL sb_bypass: busy0=%b rd0=%h, required 0 99", busy[0], rd[0]);
        end
        tick();
        we = 2'b00;
        #1;
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared: busy0=%b, required 0", busy[0]);
        end
        sb_set = 1'b1;
        we = 2'b01;
        tick();
        sb_set = 1'b0;
        we = 2'b00;
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: busy0=%b, required 1", busy[0]);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        we  = '0;
        wa  = '0;
        wd  = '0;
        ra  = '0;
`ifdef RF_SCOREBOARD_EN
        sb_set = 1'b0;
        sb_sa  = '0;
`endif
        test_reset();
        test_init_restart();
        test_multi_write();
        test_x0();
        test_back_to_back();
`ifdef RF_SCOREBOARD_EN
        test_scoreboard();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
